// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg
// Shared types and constants for the byte-FIFO access arbiter.
//   op_e           : kind of operation most recently issued to the FIFO
//   DEFAULT_DEPTH  : usable FIFO capacity (one slot is lost to the FIFO's full rule)
//   DEFAULT_DATA_W : FIFO byte width
//   STAT_W         : width of the optional blocking-statistics counters
package fifo_arb_pkg;

  typedef enum logic {
    OP_WRITE = 1'b0,
    OP_READ  = 1'b1
  } op_e;

  localparam int DEFAULT_DEPTH  = 31;
  localparam int DEFAULT_DATA_W = 8;
  localparam int STAT_W         = 16;

endpackage

// File: rtl/fifo_access_arbiter_rr_picker.sv
// rr_picker
// Purely combinational round-robin selector. Scans the eligibility mask
// starting at i_ptr in increasing index order with wrap-around and returns
// the first eligible requester as a one-hot vector.
// Ports:
//   i_elig  [NUM_WR]  eligibility mask
//   i_ptr   [PTR_W]   index where the search starts
//   o_pick  [NUM_WR]  one-hot selection (all zero when nothing is eligible)
//   o_found           at least one requester was eligible
module rr_picker #(
  parameter int NUM_WR = 4,
  parameter int PTR_W  = $clog2(NUM_WR)
) (
  input  logic [NUM_WR-1:0] i_elig,
  input  logic [PTR_W-1:0]  i_ptr,
  output logic [NUM_WR-1:0] o_pick,
  output logic              o_found
);

  // Walk the requesters in priority order. The extra bit on w_idx holds
  // i_ptr + k before the single wrap subtraction (both operands < NUM_WR).
  logic [PTR_W:0] w_idx;

  always_comb begin
    o_pick  = '0;
    o_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_WR; k++) begin
      w_idx = {1'b0, i_ptr} + (PTR_W+1)'(k);
      if (w_idx >= (PTR_W+1)'(NUM_WR)) begin
        w_idx = w_idx - (PTR_W+1)'(NUM_WR);
      end
      if (!o_found && i_elig[w_idx[PTR_W-1:0]]) begin
        o_pick[w_idx[PTR_W-1:0]] = 1'b1;
        o_found                  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_access_arbiter.sv
// fifo_access_arbiter
// Shares a byte FIFO's single write port among NUM_WR producers and its read
// port with one consumer, issuing at most one FIFO operation per cycle so the
// FIFO never sees a write and a read together. Occupancy is tracked here, so
// full/empty decisions already include operations issued but not yet landed.
// All outputs are registered.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   i_wr_req          per-producer write request, held until granted
//   i_wr_data         producer i data in bits [i*DATA_W +: DATA_W]
//   o_wr_grant        one-hot one-cycle pulse: producer data accepted
//   i_rd_req          consumer read request, held until granted
//   o_rd_grant        one-cycle pulse: read issued
//   o_rd_data_valid   one-cycle pulse aligned with the FIFO's registered data out
//   o_fifo_wr_en      FIFO write enable
//   o_fifo_wr_data    FIFO data in
//   o_fifo_rd_en      FIFO read request
//   o_count           tracked occupancy
//   o_empty / o_full  count==0 / count==DEPTH
// Optional feature, macro FIFO_ARB_STATS_EN:
//   o_wr_block_cnt    saturating count of cycles a write was blocked by full
//   o_rd_block_cnt    saturating count of cycles a read was blocked by empty
module fifo_access_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_WR = 4,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_WR-1:0]          i_wr_req,
  input  logic [NUM_WR*DATA_W-1:0]   i_wr_data,
  output logic [NUM_WR-1:0]          o_wr_grant,
  input  logic                       i_rd_req,
  output logic                       o_rd_grant,
  output logic                       o_rd_data_valid,
  output logic                       o_fifo_wr_en,
  output logic [DATA_W-1:0]          o_fifo_wr_data,
  output logic                       o_fifo_rd_en,
  output logic [$clog2(DEPTH+1)-1:0] o_count,
  output logic                       o_empty,
`ifdef FIFO_ARB_STATS_EN
  output logic [STAT_W-1:0]          o_wr_block_cnt,
  output logic [STAT_W-1:0]          o_rd_block_cnt,
`endif
  output logic                       o_full
);

  localparam int PTR_W = $clog2(NUM_WR);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [NUM_WR-1:0] r_wr_grant;
  logic              r_rd_grant;
  logic              r_rd_data_valid;
  logic              r_fifo_wr_en;
  logic [DATA_W-1:0] r_fifo_wr_data;
  logic              r_fifo_rd_en;
  logic [CNT_W-1:0]  r_count;
  logic              r_empty;
  logic              r_full;
  logic [PTR_W-1:0]  r_rr_ptr;
  op_e               r_last_op;

  logic [NUM_WR-1:0] w_wr_elig;
  logic              w_rd_elig;
  logic [NUM_WR-1:0] w_pick;
  logic              w_found;
  logic [PTR_W-1:0]  w_pick_idx;
  logic [PTR_W-1:0]  w_rr_ptr_next;
  logic [DATA_W-1:0] w_sel_data;
  logic              w_issue_wr;
  logic              w_issue_rd;
  logic [CNT_W-1:0]  w_count_next;
  op_e               w_last_op_next;

  // A requester whose grant is high this cycle is masked: its request line
  // still shows the old transfer while the producer updates it.
  always_comb begin
    w_wr_elig = i_wr_req & ~r_wr_grant & {NUM_WR{r_count < CNT_W'(DEPTH)}};
    w_rd_elig = i_rd_req & (r_count != '0) & ~r_rd_grant;
  end

  rr_picker #(
    .NUM_WR (NUM_WR)
  ) u_picker (
    .i_elig  (w_wr_elig),
    .i_ptr   (r_rr_ptr),
    .o_pick  (w_pick),
    .o_found (w_found)
  );

  // Binary index and data of the picked producer, plus the pointer that
  // starts the next search just past it.
  always_comb begin
    w_pick_idx = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      if (w_pick[i]) begin
        w_pick_idx = PTR_W'(i);
        w_sel_data = i_wr_data[i*DATA_W +: DATA_W];
      end
    end
    if (w_pick_idx == PTR_W'(NUM_WR-1)) begin
      w_rr_ptr_next = '0;
    end else begin
      w_rr_ptr_next = w_pick_idx + 1'b1;
    end
  end

  // When both sides contend, alternate against the last issued operation;
  // otherwise the lone eligible side goes. The two issue terms cannot both
  // be true, which keeps the FIFO enables exclusive.
  always_comb begin
    w_issue_wr     = w_found & (~w_rd_elig | (r_last_op == OP_READ));
    w_issue_rd     = w_rd_elig & (~w_found | (r_last_op == OP_WRITE));
    w_count_next   = r_count;
    w_last_op_next = r_last_op;
    if (w_issue_wr) begin
      w_count_next   = r_count + 1'b1;
      w_last_op_next = OP_WRITE;
    end else if (w_issue_rd) begin
      w_count_next   = r_count - 1'b1;
      w_last_op_next = OP_READ;
    end
  end

  // Registered outputs and arbitration state. A reset discards anything
  // issued but pending; the FIFO is reset on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_grant      <= '0;
      r_rd_grant      <= 1'b0;
      r_rd_data_valid <= 1'b0;
      r_fifo_wr_en    <= 1'b0;
      r_fifo_wr_data  <= '0;
      r_fifo_rd_en    <= 1'b0;
      r_count         <= '0;
      r_empty         <= 1'b1;
      r_full          <= 1'b0;
      r_rr_ptr        <= '0;
      r_last_op       <= OP_READ;
    end else begin
      r_wr_grant      <= w_issue_wr ? w_pick : '0;
      r_fifo_wr_en    <= w_issue_wr;
      r_rd_grant      <= w_issue_rd;
      r_fifo_rd_en    <= w_issue_rd;
      r_rd_data_valid <= r_rd_grant;
      r_count         <= w_count_next;
      r_empty         <= (w_count_next == '0);
      r_full          <= (w_count_next == CNT_W'(DEPTH));
      r_last_op       <= w_last_op_next;
      if (w_issue_wr) begin
        r_fifo_wr_data <= w_sel_data;
        r_rr_ptr       <= w_rr_ptr_next;
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] r_wr_block_cnt;
  logic [STAT_W-1:0] r_rd_block_cnt;

  // Blocking statistics, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_block_cnt <= '0;
      r_rd_block_cnt <= '0;
    end else begin
      if ((|i_wr_req) && r_full && (r_wr_block_cnt != '1)) begin
        r_wr_block_cnt <= r_wr_block_cnt + 1'b1;
      end
      if (i_rd_req && r_empty && (r_rd_block_cnt != '1)) begin
        r_rd_block_cnt <= r_rd_block_cnt + 1'b1;
      end
    end
  end

  assign o_wr_block_cnt = r_wr_block_cnt;
  assign o_rd_block_cnt = r_rd_block_cnt;
`endif

  assign o_wr_grant      = r_wr_grant;
  assign o_rd_grant      = r_rd_grant;
  assign o_rd_data_valid = r_rd_data_valid;
  assign o_fifo_wr_en    = r_fifo_wr_en;
  assign o_fifo_wr_data  = r_fifo_wr_data;
  assign o_fifo_rd_en    = r_fifo_rd_en;
  assign o_count         = r_count;
  assign o_empty         = r_empty;
  assign o_full          = r_full;

endmodule

// File: doc/fifo_access_arbiter.md
# fifo_access_arbiter

Shares the 8-bit byte FIFO's single write port among NUM_WR producers and its read port with one consumer. The block guarantees the FIFO never sees write and read in the same cycle, which would be a bus conflict. It tracks FIFO occupancy internally, so full and empty decisions account for operations already issued but not yet landed. It sits directly in front of the FIFO's write-enable, read-request and data-in pins.

## Interface
- NUM_WR, default 4: number of write requesters, 2..8.
- DATA_W, default 8: byte width.
- DEPTH, default 31: usable FIFO capacity (one slot is reserved by the FIFO's full rule).
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- wr_req  in  NUM_WR  per-producer write request, held until granted.
- wr_data  in  NUM_WR*DATA_W  producer i data in bits [i*DATA_W +: DATA_W].
- wr_grant  out  NUM_WR  one-hot one-cycle pulse: data accepted.
- rd_req  in  1  consumer read request, held until granted.
- rd_grant  out  1  one-cycle pulse: read issued.
- rd_data_valid  out  1  one-cycle pulse: FIFO output byte is valid.
- fifo_wr_en  out  1  to the FIFO write enable.
- fifo_wr_data  out  DATA_W  to the FIFO data in.
- fifo_rd_en  out  1  to the FIFO read request.
- count  out  $clog2(DEPTH+1)  tracked occupancy.
- empty / full  out  1  count==0 / count==DEPTH.

## Operation
- All outputs are registered.
- Writer i is eligible when wr_req[i]=1, count<DEPTH, and wr_grant[i] is not high this cycle. The last condition masks the cycle in which the producer is updating its request.
- Read is eligible when rd_req=1, count>0, and rd_grant is not high this cycle.
- At most one operation is issued per edge.
  - If only writes or only the read is eligible, issue that.
  - If both are eligible, issue the opposite of last_op: after a WRITE, issue READ; after a READ, issue WRITE. last_op resets to READ.
- Writer selection is round-robin. Search starts at rr_ptr, in increasing index order with wrap. After a grant to i, rr_ptr = (i+1) mod NUM_WR. rr_ptr resets to 0.
- Issued write: fifo_wr_en=1, fifo_wr_data=wr_data[i], wr_grant[i]=1, count+1.
- Issued read: fifo_rd_en=1, rd_grant=1, count-1.
- count never wraps, because eligibility rules prevent over- and under-run. fifo_wr_en and fifo_rd_en are never high together.
- Reset values: all grants, enables, rd_data_valid, fifo_wr_data and count are 0. empty=1, full=0, rr_ptr=0, last_op=READ.
- Reset mid-operation discards any issued-but-pending operation. The FIFO must be reset on the same edge.

## Timing
- Request sampled at edge k drives grant and FIFO enable during cycle k+1. The FIFO commits at edge k+1.
- rd_data_valid is high in cycle k+2 for a read issued at edge k, aligned with the FIFO's registered data out.
- The producer must present its next data, or drop wr_req, during the cycle its grant is high.
- Per-writer throughput is one write per 2 cycles. Aggregate throughput is one operation per cycle.
- count, empty and full update at the same edge as the issuing grant.

## Configuration
- FIFO_ARB_STATS_EN defined: adds two 16-bit saturating output ports.
  - wr_block_cnt increments each cycle with any wr_req=1 and count==DEPTH.
  - rd_block_cnt increments each cycle with rd_req=1 and count==0.
  - Both reset to 0 and saturate at 16'hFFFF.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

## Structure
- Package fifo_arb_pkg holds:
  - the op_e enum (OP_WRITE, OP_READ) for last_op;
  - DEFAULT_DEPTH=31 and DEFAULT_DATA_W=8;
  - STAT_W=16.
- Sub-module rr_picker (NUM_WR) takes eligibility mask and rr_ptr, and returns a one-hot pick and a found flag. It is purely combinational; pointer state stays in the parent.

## Test plan
- Reset, then wr_req=4'b0001, wr_data[7:0]=8'hA5 → cycle after the sampling edge: wr_grant=4'b0001, fifo_wr_en=1, fifo_wr_data=8'hA5, count=1, empty=0.
- All four writers requesting continuously, count<DEPTH → grants rotate 0001, 0010, 0100, 1000, 0001. No writer is granted on consecutive cycles.
- count=5, rd_req=1 and wr_req[2]=1 both held → issues alternate. After a write, a read follows; fifo_rd_en and fifo_wr_en are never high together. rd_data_valid follows each rd_grant by exactly 1 cycle.
- Fill to count=31 with writer 0 still requesting → full=1, no further wr_grant. One read brings count to 30 and full=0; the write is granted on the next edge.
- count=0, rd_req=1 → no rd_grant and empty stays 1. With FIFO_ARB_STATS_EN defined, rd_block_cnt increments by 1 per cycle.
- Assert reset for 1 cycle while count=12 with a write in flight → all outputs at reset values, count=0, and the next grant goes to writer 0.
